// File: rtl/uart_boot_loader_pkg.sv
// Shared command/response codes and FSM state encoding for the UART boot loader.
package uart_boot_loader_pkg;

   localparam logic [7:0] CMD_LOAD = 8'h01;
   localparam logic [7:0] CMD_RUN  = 8'h02;
   localparam logic [7:0] ACK      = 8'h06;
   localparam logic [7:0] NAK      = 8'h15;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN,
      ST_DATA,
      ST_WRITE,
      ST_RESP,
      ST_RUN
   } state_t;

endpackage

// File: rtl/uart_boot_loader_byte_word_packer.sv
// Packs payload bytes into a little-endian 32-bit word with per-lane strobes.
module uart_boot_loader_byte_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [1:0]  lane,
   input  logic        last,
   input  logic [7:0]  data,
   input  logic        clear,
   output logic [31:0] word,
   output logic [3:0]  strb,
   output logic        flush
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         word <= '0;
         strb <= '0;
      end else if (load) begin
         word[lane*8 +: 8] <= data;
         strb[lane]        <= 1'b1;
      end
   end

   // Word goes out once lane 3 fills or the final payload byte arrives.
   assign flush = load & ((lane == 2'd3) | last);

endmodule

// File: rtl/uart_boot_loader.sv
// Host load/run protocol engine: RX bytes in, firmware words to memory, ACK/NAK out.
//
// state    | meaning
// ST_IDLE  | waiting for a command byte
// ST_LEN   | collecting the 4-byte little-endian payload length
// ST_DATA  | accepting payload bytes into the packer
// ST_WRITE | one packed word on the memory bus, held until mem_ready
// ST_RESP  | sending ACK/NAK held in resp_q
// ST_RUN   | sending ACK for RUN; run pulses after the handshake
module uart_boot_loader
   import uart_boot_loader_pkg::*;
#(
   parameter int FIRM_ADDR_W = 15,
   parameter int DATA_W      = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_valid,
   input  logic [7:0]             rx_data,
   output logic                   rx_ready,
   output logic                   tx_valid,
   output logic [7:0]             tx_data,
   input  logic                   tx_ready,
   output logic                   mem_valid,
   output logic [FIRM_ADDR_W-3:0] mem_addr,
   output logic [DATA_W-1:0]      mem_wdata,
   output logic [3:0]             mem_wstrb,
   input  logic                   mem_ready,
   output logic                   run,
   output logic                   busy
);

   localparam logic [32:0] FIRM_BYTES = 33'd1 << FIRM_ADDR_W;

   state_t                 state, state_nxt;
   logic [1:0]             len_idx;
   logic [31:0]            len_q;
   logic [31:0]            byte_cnt;
   logic [FIRM_ADDR_W-3:0] word_addr;
   logic [7:0]             resp_q;
   logic                   rx_fire;
   logic [31:0]            len_next;
   logic                   len_too_big;
   logic                   pk_load;
   logic                   pk_clear;
   logic                   pk_flush;

   assign rx_fire     = rx_valid & rx_ready;
   assign len_next    = {rx_data, len_q[31:8]};
   assign len_too_big = {1'b0, len_next} > FIRM_BYTES;
   assign mem_addr    = word_addr;
   assign busy        = (state != ST_IDLE);

   uart_boot_loader_byte_word_packer u_packer (
      .clk   (clk),
      .reset (reset),
      .load  (pk_load),
      .lane  (byte_cnt[1:0]),
      .last  ((byte_cnt + 32'd1) == len_q),
      .data  (rx_data),
      .clear (pk_clear),
      .word  (mem_wdata),
      .strb  (mem_wstrb),
      .flush (pk_flush)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         len_idx   <= '0;
         len_q     <= '0;
         byte_cnt  <= '0;
         word_addr <= '0;
         resp_q    <= '0;
         run       <= 1'b0;
      end else begin
         state <= state_nxt;
         run   <= 1'b0;
         case (state)
            ST_IDLE: if (rx_fire) begin
               len_idx   <= '0;
               byte_cnt  <= '0;
               word_addr <= '0;
               resp_q    <= NAK;
            end
            ST_LEN: if (rx_fire) begin
               len_q   <= len_next;
               len_idx <= len_idx + 2'd1;
               resp_q  <= len_too_big ? NAK : ACK;
            end
            ST_DATA:  if (rx_fire) byte_cnt <= byte_cnt + 32'd1;
            ST_WRITE: if (mem_ready) begin
               word_addr <= word_addr + (FIRM_ADDR_W-2)'(1);
               resp_q    <= ACK;
            end
            ST_RUN:   if (tx_ready) run <= 1'b1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      rx_ready  = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = '0;
      mem_valid = 1'b0;
      pk_load   = 1'b0;
      pk_clear  = 1'b0;
      case (state)
         ST_IDLE: begin
            rx_ready = 1'b1;
            if (rx_valid) begin
               if (rx_data == CMD_LOAD)     state_nxt = ST_LEN;
               else if (rx_data == CMD_RUN) state_nxt = ST_RUN;
               else                         state_nxt = ST_RESP;
            end
         end
         ST_LEN: begin
            rx_ready = 1'b1;
            if (rx_valid && len_idx == 2'd3) begin
               if (len_too_big || len_next == 32'd0) state_nxt = ST_RESP;
               else                                  state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            rx_ready = 1'b1;
            pk_load  = rx_valid;
            if (pk_flush) state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            mem_valid = 1'b1;
            if (mem_ready) begin
               pk_clear  = 1'b1;
               state_nxt = (byte_cnt == len_q) ? ST_RESP : ST_DATA;
            end
         end
         ST_RESP: begin
            tx_valid = 1'b1;
            tx_data  = resp_q;
            if (tx_ready) state_nxt = ST_IDLE;
         end
         ST_RUN: begin
            tx_valid = 1'b1;
            tx_data  = ACK;
            if (tx_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: load/run protocol, packing, stalls, reset abort.
module tb_uart_boot_loader;

   localparam int FIRM_ADDR_W = 15;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   rx_valid = 1'b0;
   logic [7:0]             rx_data = 8'h00;
   logic                   rx_ready;
   logic                   tx_valid;
   logic [7:0]             tx_data;
   logic                   tx_ready = 1'b1;
   logic                   mem_valid;
   logic [FIRM_ADDR_W-3:0] mem_addr;
   logic [31:0]            mem_wdata;
   logic [3:0]             mem_wstrb;
   logic                   mem_ready = 1'b1;
   logic                   run;
   logic                   busy;

   uart_boot_loader #(.FIRM_ADDR_W(FIRM_ADDR_W), .DATA_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .rx_ready  (rx_ready),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .mem_valid (mem_valid),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ready (mem_ready),
      .run       (run),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   logic [31:0] wr_strb_q[$];
   int          lat_q[$];
   logic [7:0]  tx_q[$];
   int cyc = 0;
   int last_rx_cyc = 0;
   int tx_cyc = 0;
   int run_cyc = 0;
   int run_cnt = 0;
   int run_busy = 0;
   int stall_left = 0;
   int stall_cycles = 0;
   int stall_viol = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr, prev_data, prev_strb;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitors; a single block keeps the cycle stamps consistent.
   always @(posedge clk) begin
      if (rx_valid && rx_ready) last_rx_cyc = cyc;
      if (mem_valid && mem_ready) begin
         wr_addr_q.push_back(32'(mem_addr));
         wr_data_q.push_back(mem_wdata);
         wr_strb_q.push_back({28'd0, mem_wstrb});
         lat_q.push_back(cyc - last_rx_cyc);
      end
      if (mem_valid && !mem_ready) begin
         stall_cycles++;
         if (rx_ready) stall_viol++;
         if (prev_stall && (32'(mem_addr) != prev_addr || mem_wdata != prev_data ||
                            {28'd0, mem_wstrb} != prev_strb)) stall_viol++;
         prev_stall = 1'b1;
         prev_addr  = 32'(mem_addr);
         prev_data  = mem_wdata;
         prev_strb  = {28'd0, mem_wstrb};
      end else begin
         prev_stall = 1'b0;
      end
      if (tx_valid && tx_ready) begin
         tx_q.push_back(tx_data);
         tx_cyc = cyc;
      end
      if (run) begin
         run_cnt++;
         run_cyc = cyc;
         if (busy) run_busy++;
      end
      cyc++;
   end

   always @(negedge clk) begin
      if (mem_valid && stall_left > 0) begin
         mem_ready = 1'b0;
         stall_left--;
      end else begin
         mem_ready = 1'b1;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = b;
      n = 0;
      while (!rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("rx_timeout", 64'(n), 64'd0);
      @(posedge clk);
      #1 rx_valid = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] n);
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
   endtask

   task automatic send_payload(input int n, input logic [7:0] base, input logic [7:0] step);
      logic [7:0] b;
      b = base;
      for (int i = 0; i < n; i++) begin
         send_byte(b);
         b = b + step;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 64'(n), 64'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_strb_q.delete();
      lat_q.delete();
      tx_q.delete();
      run_cnt = 0;
      run_busy = 0;
      stall_cycles = 0;
      stall_viol = 0;
   endtask

   task automatic chk_write(input string tag, input int idx, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
      if (idx < wr_addr_q.size()) begin
         chk({tag, "_addr"}, 64'(wr_addr_q[idx]), 64'(addr));
         chk({tag, "_data"}, 64'(wr_data_q[idx]), 64'(data));
         chk({tag, "_strb"}, 64'(wr_strb_q[idx]), 64'(strb));
      end else begin
         chk({tag, "_missing"}, 64'(wr_addr_q.size()), 64'(idx + 1));
      end
   endtask

   task automatic chk_resp(input string tag, input logic [7:0] code);
      chk({tag, "_tx_count"}, 64'(tx_q.size()), 64'd1);
      if (tx_q.size() > 0) chk({tag, "_tx_byte"}, 64'(tx_q[0]), 64'(code));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_rx_ready", 64'(rx_ready), 64'd1);
      chk("rst_outputs", 64'({tx_valid, mem_valid, run, busy}), 64'd0);
      chk("rst_buses", 64'({tx_data, mem_wdata, mem_wstrb, 32'(mem_addr)}), 64'd0);

      // 1: eight bytes, two full words, zero-wait memory
      clear_logs();
      send_byte(8'h01); send_len(32'd8); send_payload(8, 8'h00, 8'h01);
      wait_idle();
      chk("t1_nwrites", 64'(wr_addr_q.size()), 64'd2);
      chk_write("t1_w0", 0, 32'd0, 32'h03020100, 4'hF);
      chk_write("t1_w1", 1, 32'd1, 32'h07060504, 4'hF);
      if (lat_q.size() > 0) chk("t1_latency", 64'(lat_q[0]), 64'd1);
      chk_resp("t1", 8'h06);

      // 2: partial last word, address restarts at 0
      clear_logs();
      send_byte(8'h01); send_len(32'd5); send_payload(5, 8'hAA, 8'h11);
      wait_idle();
      chk("t2_nwrites", 64'(wr_addr_q.size()), 64'd2);
      chk_write("t2_w0", 0, 32'd0, 32'hDDCCBBAA, 4'hF);
      chk_write("t2_w1", 1, 32'd1, 32'h000000EE, 4'b0001);
      chk_resp("t2", 8'h06);

      // 3: memory stalls 10 cycles on the first word
      clear_logs();
      stall_left = 10;
      send_byte(8'h01); send_len(32'd8); send_payload(8, 8'h10, 8'h01);
      wait_idle();
      chk("t3_stall_cycles", 64'(stall_cycles), 64'd10);
      chk("t3_stall_viol", 64'(stall_viol), 64'd0);
      chk_write("t3_w0", 0, 32'd0, 32'h13121110, 4'hF);
      chk_write("t3_w1", 1, 32'd1, 32'h17161514, 4'hF);
      chk_resp("t3", 8'h06);

      // 4: unknown command, then oversize length
      clear_logs();
      send_byte(8'h7F);
      wait_idle();
      chk_resp("t4_badcmd", 8'h15);
      clear_logs();
      send_byte(8'h01); send_len(32'd32769);
      wait_idle();
      chk_resp("t4_toobig", 8'h15);
      chk("t4_nwrites", 64'(wr_addr_q.size()), 64'd0);
      chk("t4_busy", 64'(busy), 64'd0);

      // 5: empty load, then run
      clear_logs();
      send_byte(8'h01); send_len(32'd0);
      wait_idle();
      chk_resp("t5_zero", 8'h06);
      chk("t5_nwrites", 64'(wr_addr_q.size()), 64'd0);
      clear_logs();
      send_byte(8'h02);
      wait_idle();
      chk_resp("t5_run", 8'h06);
      chk("t5_run_pulses", 64'(run_cnt), 64'd1);
      chk("t5_run_busy", 64'(run_busy), 64'd0);
      chk("t5_run_timing", 64'(run_cyc - tx_cyc), 64'd1);
      chk("t5_busy", 64'(busy), 64'd0);

      // 6: reset mid-word discards the partial word
      clear_logs();
      send_byte(8'h01); send_len(32'd4); send_payload(2, 8'h55, 8'h01);
      @(negedge clk); reset = 1'b1;
      repeat (2) @(negedge clk); reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_no_write", 64'(wr_addr_q.size()), 64'd0);
      chk("t6_idle", 64'({busy, rx_ready}), 64'b01);
      send_byte(8'h01); send_len(32'd4); send_payload(4, 8'h21, 8'h01);
      wait_idle();
      chk("t6_nwrites", 64'(wr_addr_q.size()), 64'd1);
      chk_write("t6_w0", 0, 32'd0, 32'h24232221, 4'hF);
      chk_resp("t6", 8'h06);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
